// File: rtl/inst_fetch_ctrl.sv
// ----------------------------------------------------------------------------
// inst_fetch_ctrl
//
// Instruction-fetch requester. Owns the architectural fetch PC, issues one
// SRAM-like read at a time to instruction memory, and holds one fetched
// instruction for decode until decode accepts it or a redirect flushes it.
//
// State | meaning
// ------+----------------------------------------------------------------
// IDLE  | one-cycle start after reset; stale memory responses are ignored
// REQ   | presenting inst_req at pc (or raising a misaligned-fetch fault)
// WAIT  | request accepted, waiting for data_ok (discard drops stale data)
// HOLD  | if_* entry held for decode until accept or redirect
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   npc, redirect       next PC / redirect target and flush request
//   stall               pipeline stall, blocks decode acceptance
//   pc                  current fetch PC, fed back to next-PC logic
//   req_inst_success    one-cycle pulse when decode accepts the held entry
//   inst_req/inst_addr  memory request valid and address
//   inst_addr_ok        memory accepted the request
//   inst_data_ok        memory returned read data on inst_rdata
//   if_valid/if_pc/if_inst/if_adef   held entry presented to decode
//   id_allowin          decode can accept
//   fetch_cnt           number of entries delivered to decode (wraps)
// ----------------------------------------------------------------------------
module inst_fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h1C00_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      npc,
    input  logic             redirect,
    input  logic             stall,
    output logic [31:0]      pc,
    output logic             req_inst_success,
    output logic             inst_req,
    output logic [31:0]      inst_addr,
    input  logic             inst_addr_ok,
    input  logic             inst_data_ok,
    input  logic [31:0]      inst_rdata,
    output logic             if_valid,
    output logic [31:0]      if_pc,
    output logic [31:0]      if_inst,
    output logic             if_adef,
    input  logic             id_allowin,
    output logic [CNT_W-1:0] fetch_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t state;
    logic   discard;
    logic   misaligned;
    logic   accept;
    logic   req_taken;

    assign misaligned = (pc[1:0] != 2'b00);

    // A misaligned PC never reaches memory; it becomes a fault entry instead.
    assign inst_req  = (state == REQ) && !misaligned;
    assign inst_addr = pc;

    // Redirect wins over acceptance, so a flushed entry never counts.
    assign accept           = (state == HOLD) && if_valid && id_allowin && !stall && !redirect;
    assign req_inst_success = accept;

    assign req_taken = inst_req && inst_addr_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pc        <= RESET_PC;
            discard   <= 1'b0;
            if_valid  <= 1'b0;
            if_pc     <= 32'h0;
            if_inst   <= 32'h0;
            if_adef   <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state <= REQ;
                    if (redirect) begin
                        pc <= npc;
                    end
                end

                REQ: begin
                    if (redirect) begin
                        pc <= npc;
                        // Request went out at the old pc; its reply must be dropped.
                        if (req_taken) begin
                            discard <= 1'b1;
                            state   <= WAIT;
                        end
                    end else if (misaligned) begin
                        if_valid <= 1'b1;
                        if_adef  <= 1'b1;
                        if_inst  <= 32'h0;
                        if_pc    <= pc;
                        state    <= HOLD;
                    end else if (req_taken) begin
                        state <= WAIT;
                    end
                end

                WAIT: begin
                    if (redirect) begin
                        pc <= npc;
                        if (inst_data_ok) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            discard <= 1'b1;
                        end
                    end else if (inst_data_ok) begin
                        if (discard) begin
                            discard <= 1'b0;
                            state   <= REQ;
                        end else begin
                            if_inst  <= inst_rdata;
                            if_pc    <= pc;
                            if_adef  <= 1'b0;
                            if_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end

                HOLD: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        pc       <= npc;
                        state    <= REQ;
                    end else if (accept) begin
                        fetch_cnt <= fetch_cnt + CNT_W'(1);
                        if_valid  <= 1'b0;
                        pc        <= npc;
                        state     <= REQ;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/inst_fetch_ctrl.md
Name: inst_fetch_ctrl

Overview:
- Instruction-fetch requester. Consumes the next-PC value produced by the next-PC logic and owns the architectural fetch PC, which it feeds back to that logic.
- Issues SRAM-like requests to instruction memory (req/addr_ok/data_ok) and holds one fetched instruction for the decode stage.
- Handles redirects (exception entry, taken branch/jump) while a request is in flight.
- Generates req_inst_success, the per-instruction fetch-complete pulse.

Parameters:
- RESET_PC, 32'h1C00_0000, fetch PC loaded on reset.
- CNT_W, 32, width of the fetched-instruction performance counter.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- npc  in  32  next PC from next-PC logic; holds the redirect target when redirect=1.
- redirect  in  1  flush current fetch and load npc (exception or taken control transfer).
- stall  in  1  pipeline stall; decode must not accept.
- pc  out  32  current fetch PC, fed to next-PC logic.
- req_inst_success  out  1  one-cycle pulse when decode accepts an instruction.
- inst_req  out  1  memory request valid.
- inst_addr  out  32  memory request address.
- inst_addr_ok  in  1  request accepted.
- inst_data_ok  in  1  read data returned.
- inst_rdata  in  32  read data.
- if_valid  out  1  if_pc/if_inst/if_adef valid to decode.
- if_pc  out  32  PC of held instruction.
- if_inst  out  32  held instruction word.
- if_adef  out  1  held entry is a misaligned-fetch fault.
- id_allowin  in  1  decode can accept.
- fetch_cnt  out  CNT_W  instructions delivered.

Behaviour:
- Reset (async):
  - state=IDLE, pc=RESET_PC, discard=0, if_valid=0, if_pc=0, if_inst=0, if_adef=0, fetch_cnt=0.
  - inst_req=0, req_inst_success=0.
- inst_req=(state==REQ); inst_addr=pc. Both are combinational from registers.
- States: IDLE, REQ, WAIT, HOLD. At most one request outstanding.
- IDLE: next cycle goes to REQ. A data_ok seen in IDLE (a response left over from before reset) is ignored.
- REQ:
  - If pc[1:0]!=0: no request. inst_req=0 in this case, overriding the rule above. Go to HOLD with if_adef=1, if_inst=0, if_pc=pc.
  - Otherwise assert inst_req. On addr_ok, go to WAIT.
  - redirect without addr_ok: pc<=npc, stay in REQ. The address may change before acceptance.
  - redirect with addr_ok in the same cycle: pc<=npc, discard<=1, go to WAIT.
- WAIT:
  - data_ok with discard=1: discard<=0, go to REQ. Data is dropped.
  - data_ok with discard=0: if_inst<=inst_rdata, if_pc<=pc, if_adef<=0, if_valid<=1, go to HOLD.
  - redirect (with or without data_ok): pc<=npc. Without data_ok, discard<=1 and stay in WAIT. With data_ok, drop the data and go to REQ.
- HOLD:
  - Accept when if_valid && id_allowin && !stall && !redirect. On accept:
    - req_inst_success=1 for that cycle (combinational), fetch_cnt++ (wraps at 2^CNT_W).
    - pc<=npc, if_valid<=0, go to REQ.
  - redirect: if_valid<=0, pc<=npc, go to REQ. No success pulse, no count.
  - Otherwise hold all outputs stable.
- Priority: rst > redirect > accept/data_ok > hold.
- pc changes only on reset, redirect, or accept.
- discard is at most 1; no second request is issued while in WAIT.

Test Plan:
- Reset, then addr_ok after 1 cycle and data_ok 2 cycles later with rdata=0x02800C21, id_allowin=1 -> inst_addr=0x1C000000, if_inst=0x02800C21, one success pulse, pc=npc=0x1C000004, fetch_cnt=1.
- In HOLD, id_allowin=0 for 3 cycles, then 1 -> outputs stable for 3 cycles; exactly one pulse on release.
- Redirect npc=0x1C000100 in WAIT, then data_ok with rdata=0xDEADBEEF -> data dropped, if_valid stays 0, next inst_addr=0x1C000100.
- Redirect in the same cycle as addr_ok -> that response is discarded; the next request goes to the target address.
- Misaligned npc=0x1C000102 -> no inst_req; if_valid=1, if_adef=1, if_inst=0. Redirect npc=0x1C008000 -> REQ at 0x1C008000.
- Reset asserted in WAIT, then data_ok arrives after release -> ignored; first request is at RESET_PC, fetch_cnt=0.
